// File: rtl/external_scan_ctrl_pkg.sv
// Shared encodings and geometry helpers for the external S-bit scan sequencer.
package external_scan_ctrl_pkg;

    localparam logic [1:0] MODE_VFAT   = 2'b00;
    localparam logic [1:0] MODE_ETA    = 2'b01;
    localparam logic [1:0] MODE_SECTOR = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam int NUM_CHANNELS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL,
        ST_STEP,
        ST_DONE
    } state_e;

    // Number of selectable sources for a mode; MODE_OFF has none.
    function automatic logic [5:0] source_count(input logic [1:0] mode,
                                                input logic       ge21,
                                                input logic [5:0] num_vfats);
        case (mode)
            MODE_VFAT:   return num_vfats;
            MODE_ETA:    return ge21 ? 6'd2 : 6'd8;
            MODE_SECTOR: return 6'd6;
            default:     return 6'd0;
        endcase
    endfunction

    // Steps needed to cover n sources, eight per step.
    function automatic logic [1:0] step_count(input logic [5:0] n);
        logic [5:0] steps;
        steps = (n + 6'd7) >> 3;
        return steps[1:0];
    endfunction

endpackage

// File: rtl/external_scan_ctrl_cfg_gen.sv
// Maps (step, mode, geometry) to the per-channel mode/select buses of one scan step.
module scan_cfg_gen
    import external_scan_ctrl_pkg::*;
#(
    parameter bit GE21      = 1'b0,
    parameter int NUM_VFATS = 24
) (
    input  logic [1:0]  step_i,
    input  logic [1:0]  mode_i,
    output logic [15:0] sbit_mode_o,
    output logic [39:0] sbit_sel_o
);

    logic [5:0] n_src;
    logic [5:0] src;

    always_comb begin
        n_src       = source_count(mode_i, GE21, 6'(NUM_VFATS));
        sbit_mode_o = '0;
        sbit_sel_o  = '0;
        src         = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            src = {1'b0, step_i, 3'(k)};
            if (src < n_src) begin
                sbit_mode_o[2*k +: 2] = mode_i;
                sbit_sel_o[5*k +: 5]  = src[4:0];
            end else begin
                sbit_mode_o[2*k +: 2] = MODE_OFF;
            end
        end
    end

endmodule

// File: rtl/external_scan_ctrl.sv
// Scan sequencer for the 8 external S-bit outputs: static passthrough in IDLE,
// stepped source scan with settle/dwell windows otherwise.
module external_scan_ctrl
    import external_scan_ctrl_pkg::*;
#(
    parameter bit GE21          = 1'b0,
    parameter int NUM_VFATS     = 24,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        continuous_i,
    input  logic [1:0]  scan_mode_i,
    input  logic [15:0] dwell_i,
    input  logic [15:0] static_mode_i,
    input  logic [39:0] static_sel_i,
    output logic [15:0] sbit_mode_o,
    output logic [39:0] sbit_sel_o,
    output logic        busy_o,
    output logic        window_o,
    output logic [1:0]  step_o,
    output logic        done_o,
    output logic        error_o
);

    localparam logic [5:0]  NV          = 6'(NUM_VFATS);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] dwell_q, dwell_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] sbit_mode_q, sbit_mode_d;
    logic [39:0] sbit_sel_q, sbit_sel_d;
    logic        busy_q, busy_d;
    logic        window_q, window_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        load_cfg;
    logic [1:0]  last_step;
    logic [15:0] cfg_mode;
    logic [39:0] cfg_sel;

    // Driven with the next step/mode so the new config lands on the SETTLE entry edge.
    scan_cfg_gen #(
        .GE21      (GE21),
        .NUM_VFATS (NUM_VFATS)
    ) u_cfg_gen (
        .step_i      (step_d),
        .mode_i      (mode_d),
        .sbit_mode_o (cfg_mode),
        .sbit_sel_o  (cfg_sel)
    );

    assign last_step = step_count(source_count(mode_q, GE21, NV)) - 2'd1;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        mode_d   = mode_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        cnt_d    = cnt_q;
        error_d  = 1'b0;
        load_cfg = 1'b0;
        case (state_q)
            ST_IDLE: begin
                step_d = 2'd0;
                if (start_i && !stop_i) begin
                    if (scan_mode_i == MODE_OFF) begin
                        error_d = 1'b1;
                    end else begin
                        state_d  = ST_SETTLE;
                        mode_d   = scan_mode_i;
                        dwell_d  = (dwell_i == 16'd0) ? 16'd1 : dwell_i;
                        cnt_d    = SETTLE_LOAD;
                        load_cfg = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_DWELL;
                    cnt_d   = dwell_q - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_DWELL: begin
                if (cnt_q == 16'd0) state_d = ST_STEP;
                else                cnt_d   = cnt_q - 16'd1;
            end
            ST_STEP: begin
                if (step_q == last_step && !continuous_i) begin
                    state_d = ST_DONE;
                end else begin
                    step_d   = (step_q == last_step) ? 2'd0 : step_q + 2'd1;
                    state_d  = ST_SETTLE;
                    cnt_d    = SETTLE_LOAD;
                    load_cfg = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (stop_i && state_q != ST_IDLE) begin
            state_d  = ST_IDLE;
            load_cfg = 1'b0;
        end
        if (state_d == ST_IDLE) step_d = 2'd0;
    end

    // Output config and status are a function of the next state, so they register with it.
    always_comb begin
        sbit_mode_d = sbit_mode_q;
        sbit_sel_d  = sbit_sel_q;
        if (state_d == ST_IDLE) begin
            sbit_mode_d = static_mode_i;
            sbit_sel_d  = static_sel_i;
        end else if (load_cfg) begin
            sbit_mode_d = cfg_mode;
            sbit_sel_d  = cfg_sel;
        end
        busy_d   = (state_d != ST_IDLE);
        window_d = (state_d == ST_DWELL);
        done_d   = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_VFAT;
            step_q      <= 2'd0;
            dwell_q     <= 16'd1;
            cnt_q       <= 16'd0;
            sbit_mode_q <= {NUM_CHANNELS{MODE_OFF}};
            sbit_sel_q  <= '0;
            busy_q      <= 1'b0;
            window_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            sbit_mode_q <= sbit_mode_d;
            sbit_sel_q  <= sbit_sel_d;
            busy_q      <= busy_d;
            window_q    <= window_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign sbit_mode_o = sbit_mode_q;
    assign sbit_sel_o  = sbit_sel_q;
    assign busy_o      = busy_q;
    assign window_o    = window_q;
    assign step_o      = step_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule
